// File: rtl/timer_unit.sv
// Memory-mapped down-counting timer with an interrupt on expiry.
// Register map (word offset addr[3:2]): 0 CTRL, 1 PRESET, 2 COUNT (read-only),
// 3 reserved. CTRL = {IM, MODE[1:0], EN}; MODE 01 is auto-reload, anything
// else is one-shot.
module timer_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCnt,
    StInt
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;
  logic        irq_q, irq_d;

  logic wr_ctrl, wr_preset;
  logic en_eff, auto_mode;

  assign wr_ctrl   = we & (addr[3:2] == 2'd0);
  assign wr_preset = we & (addr[3:2] == 2'd1);

  // A CTRL write landing this edge takes effect immediately for stop decisions,
  // so the timer halts without loading or decrementing once more.
  assign en_eff    = wr_ctrl ? wdata[0] : ctrl_q[0];
  assign auto_mode = (ctrl_q[2:1] == 2'b01);

  // Next-state: FSM update first, then software writes override hardware updates.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    unique case (state_q)
      StIdle: begin
        // Start uses the registered EN, giving one idle cycle after the write.
        if (ctrl_q[0]) begin
          state_d = StLoad;
          flag_d  = 1'b0;
        end
      end
      StLoad: begin
        if (!en_eff) begin
          state_d = StIdle;
        end else begin
          count_d = preset_q;
          state_d = StCnt;
        end
      end
      StCnt: begin
        if (!en_eff) begin
          state_d = StIdle;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Also covers PRESET=0: expire instead of wrapping.
          count_d = 32'd0;
          flag_d  = 1'b1;
          state_d = StInt;
        end
      end
      StInt: begin
        if (auto_mode) begin
          flag_d  = 1'b0;
          state_d = StLoad;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr_ctrl) begin
      ctrl_d = wdata[3:0];
    end
    if (wr_preset) begin
      preset_d = wdata;
    end
    // One-shot flag is acknowledged by any CTRL/PRESET write.
    if (!auto_mode && (wr_ctrl || wr_preset)) begin
      flag_d = 1'b0;
    end
  end

  // irq is registered from next-state values so it rises on the expiry edge.
  assign irq_d = flag_d & ctrl_d[3];

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      irq_q    <= irq_d;
    end
  end

  // Combinational read mux.
  always_comb begin
    rdata = 32'd0;
    unique case (addr[3:2])
      2'd0:    rdata = {28'd0, ctrl_q};
      2'd1:    rdata = preset_q;
      2'd2:    rdata = count_q;
      default: rdata = 32'd0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_timer_unit.sv
// Directed bench for timer_unit: one task per scenario, inline checks.
module tb_timer_unit;

  logic        clk;
  logic        reset;
  logic [31:2] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_cmp;
  int n_fail;

  timer_unit dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Register write; returns just after the write edge.
  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    addr  = {28'd0, off};
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] off, output logic [31:0] d);
    addr = {28'd0, off};
    #1;
    d = rdata;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1;
    we    = 1'b0;
    wdata = 32'd0;
    addr  = '0;
    #12;
    for (int i = 0; i < 4; i++) begin
      rd(i[1:0], v);
      n_cmp++;
      if (v !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_rdata off=%0d got=%h exp=0", i, v);
      end
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_oneshot;
    logic [31:0] v;
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick(2);
    for (int i = 0; i < 5; i++) begin
      rd(2'd2, v);
      n_cmp++;
      if (v !== 32'(5 - i) || irq !== 1'b0) begin
        n_fail++;
        $display("FAIL oneshot_count E%0d got=%0d irq=%b exp=%0d irq=0", i + 2, v, irq, 5 - i);
      end
      tick(1);
    end
    // After E7
    rd(2'd2, v);
    n_cmp++;
    if (irq !== 1'b1 || v !== 32'd0) begin
      n_fail++;
      $display("FAIL oneshot_expiry irq=%b count=%0d exp irq=1 count=0", irq, v);
    end
    tick(1);
    rd(2'd0, v);
    n_cmp++;
    if (v !== 32'h8 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_ctrl_clear ctrl=%h irq=%b exp ctrl=8 irq=1", v, irq);
    end
    tick(3);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_irq_hold got=%b exp=1", irq);
    end
    wr(2'd0, 32'h0);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_irq_ack got=%b exp=0", irq);
    end
  endtask

  task automatic test_reset_midcount;
    logic [31:0] v;
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick(4);
    rd(2'd2, v);
    n_cmp++;
    if (v !== 32'd3) begin
      n_fail++;
      $display("FAIL midreset_pre count=%0d exp=3", v);
    end
    #1;
    reset = 1'b1;
    rd(2'd2, v);
    n_cmp++;
    if (v !== 32'd0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async count=%0d irq=%b exp 0 0", v, irq);
    end
    rd(2'd0, v);
    n_cmp++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_ctrl got=%h exp=0", v);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      rd(2'd2, v);
      n_cmp++;
      if (irq !== 1'b0 || v !== 32'd0) begin
        n_fail++;
        $display("FAIL midreset_idle cyc=%0d irq=%b count=%0d exp 0 0", i, irq, v);
      end
      tick(1);
    end
  endtask

  task automatic test_autoreload;
    logic [31:0] v;
    logic        exp_irq;
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 22; k++) begin
      tick(1);
      exp_irq = (k >= 5) && ((k - 5) % 5 == 0);
      n_cmp++;
      if (irq !== exp_irq) begin
        n_fail++;
        $display("FAIL auto_irq E%0d got=%b exp=%b", k, irq, exp_irq);
      end
      if (k == 7) begin
        rd(2'd2, v);
        n_cmp++;
        if (v !== 32'd3) begin
          n_fail++;
          $display("FAIL auto_reload_count got=%0d exp=3", v);
        end
      end
    end
    wr(2'd0, 32'h0);
    tick(2);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_stop irq got=%b exp=0", irq);
    end
  endtask

  task automatic test_mask_preset0;
    logic [31:0] v;
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      n_cmp++;
      if (irq !== 1'b0) begin
        n_fail++;
        $display("FAIL mask_irq E%0d got=%b exp=0", k, irq);
      end
    end
    rd(2'd0, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL mask_en_clear ctrl=%h exp=0", v);
    end
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      n_cmp++;
      if (irq !== (k == 3)) begin
        n_fail++;
        $display("FAIL preset0_irq E%0d got=%b exp=%b", k, irq, (k == 3));
      end
    end
    wr(2'd0, 32'h0);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL preset0_ack got=%b exp=0", irq);
    end
  endtask

  task automatic test_stop_restart;
    logic [31:0] v;
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick(5);
    rd(2'd2, v);
    n_cmp++;
    if (v !== 32'd2) begin
      n_fail++;
      $display("FAIL stop_pre count=%0d exp=2", v);
    end
    wr(2'd0, 32'h0);
    tick(3);
    rd(2'd2, v);
    n_cmp++;
    if (v !== 32'd2 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_frozen count=%0d irq=%b exp 2 0", v, irq);
    end
    wr(2'd2, 32'hDEAD);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd2, v);
    n_cmp++;
    if (v !== 32'd2) begin
      n_fail++;
      $display("FAIL count_readonly got=%0d exp=2", v);
    end
    rd(2'd3, v);
    n_cmp++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("FAIL reserved_read got=%h exp=0", v);
    end
    rd(2'd0, v);
    n_cmp++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("FAIL reserved_no_alias_ctrl got=%h exp=0", v);
    end
    rd(2'd1, v);
    n_cmp++;
    if (v !== 32'd5) begin
      n_fail++;
      $display("FAIL reserved_no_alias_preset got=%0d exp=5", v);
    end
    wr(2'd0, 32'h9);
    tick(2);
    rd(2'd2, v);
    n_cmp++;
    if (v !== 32'd5) begin
      n_fail++;
      $display("FAIL restart_reload got=%0d exp=5", v);
    end
    tick(5);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_irq got=%b exp=1", irq);
    end
    wr(2'd0, 32'h0);
  endtask

  task automatic test_priority;
    logic [31:0] v;
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    tick(4);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_expiry irq=%b exp=1", irq);
    end
    // Write lands on the INT edge, same edge as the hardware EN clear.
    wr(2'd0, 32'h9);
    rd(2'd0, v);
    n_cmp++;
    if (v !== 32'h9 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_ctrl ctrl=%h irq=%b exp ctrl=9 irq=0", v, irq);
    end
    tick(2);
    rd(2'd2, v);
    n_cmp++;
    if (v !== 32'd2) begin
      n_fail++;
      $display("FAIL prio_recount got=%0d exp=2", v);
    end
    tick(2);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_second_irq got=%b exp=1", irq);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_oneshot();
    test_reset_midcount();
    test_autoreload();
    test_mask_preset0();
    test_stop_restart();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
